// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module     : count_monitor
// Description: Tracks a 4-bit upstream counter, counting 15->0 wraps and
//              sequence errors. Optional macro NUM_CHECK_EN adds a real
//              accumulator check (num/num_err ports, restart detection).
// Revision   : 1.0 - initial release
// ============================================================================
module count_monitor #(
  parameter int  WRAP_W = 8,
  parameter real STEP   = 0.5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        count,
`ifdef NUM_CHECK_EN
  input  real               num,
`endif
  input  logic              clr_err,
  output logic              locked,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [7:0]        err_cnt
`ifdef NUM_CHECK_EN
  ,
  output logic              num_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              num_err_q, num_err_d;
  logic              locked_q;

  logic              w_cnt_mis;
  logic              w_num_mis;
  logic              w_restart;
  logic              w_wrap_hit;
  logic              w_checking;
  logic              w_clear;

`ifdef NUM_CHECK_EN
  real prev_num_q, prev_num_d;
  // A zeroed counter and accumulator together mean upstream restarted, unless
  // it is the legitimate 15->0 wrap.
  assign w_restart = (count == 4'd0) && (num == 0.0) && (prev_q != 4'hF);
  assign w_num_mis = !w_restart && (num != prev_num_q + STEP);
`else
  assign w_restart = 1'b0;
  assign w_num_mis = 1'b0;
`endif

  assign w_cnt_mis  = (count != prev_q + 4'd1);
  assign w_wrap_hit = (prev_q == 4'hF) && (count == 4'd0);
  assign w_checking = en && (state_q != IDLE) && !w_restart;
  assign w_clear    = clr_err && !(w_checking && (w_cnt_mis || w_num_mis));

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    wrap_d    = wrap_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    num_err_d = num_err_q;
`ifdef NUM_CHECK_EN
    prev_num_d = prev_num_q;
`endif
    if (en) begin
      if (state_q == IDLE) begin
        prev_d  = count;
        state_d = TRACK;
`ifdef NUM_CHECK_EN
        prev_num_d = num;
`endif
      end else if (w_restart) begin
        prev_d = 4'd0;
`ifdef NUM_CHECK_EN
        prev_num_d = 0.0;
`endif
      end else begin
        prev_d = count;
`ifdef NUM_CHECK_EN
        prev_num_d = num;
`endif
        if (w_wrap_hit) begin
          wrap_d = wrap_q + WRAP_W'(1);
        end
        // A sample with both mismatches is still a single error event.
        if ((w_cnt_mis || w_num_mis) && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        if (w_cnt_mis) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end
        if (w_num_mis) begin
          num_err_d = 1'b1;
        end
      end
    end
    if (w_clear) begin
      err_d     = 1'b0;
      num_err_d = 1'b0;
      if (state_q == ERROR) begin
        state_d = TRACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      prev_q    <= 4'd0;
      wrap_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      num_err_q <= 1'b0;
      locked_q  <= 1'b0;
`ifdef NUM_CHECK_EN
      prev_num_q <= 0.0;
`endif
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      num_err_q <= num_err_d;
      locked_q  <= (state_d != IDLE);
`ifdef NUM_CHECK_EN
      prev_num_q <= prev_num_d;
`endif
    end
  end

  assign locked   = locked_q;
  assign wrap_cnt = wrap_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
`ifdef NUM_CHECK_EN
  assign num_err  = num_err_q;
`endif

endmodule
`default_nettype wire

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WRAP_W, default 8: width of the wrap counter.
REQ-002 Parameter STEP (real), default 0.5: expected per-sample increment of num.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-005 en  input  1  sample strobe; 1 = evaluate count/num this cycle.
REQ-006 count  input  4  upstream counter value.
REQ-007 num  input  real  upstream real accumulator (present only with NUM_CHECK_EN).
REQ-008 clr_err  input  1  clears sticky error flags.
REQ-009 locked  output  1  1 when FSM in TRACK or ERROR.
REQ-010 wrap_cnt  output  WRAP_W  number of 15->0 transitions seen.
REQ-011 err  output  1  sticky count-sequence error.
REQ-012 err_cnt  output  8  total errors, saturating at 255.
REQ-013 num_err  output  1  sticky num-mismatch error (present only with NUM_CHECK_EN).

Function
REQ-014 All outputs SHALL be registered; each sample's effect SHALL be visible the cycle after the sampling edge.
REQ-015 en=0 SHALL hold all state and outputs unchanged, except clr_err, which SHALL still take effect.
REQ-016 FSM states SHALL be IDLE, TRACK and ERROR.
REQ-017 IDLE with en=1: capture count (and num) as prev, then go to TRACK; no error check in IDLE.
REQ-018 TRACK/ERROR with en=1: the expected count SHALL be (prev+1) mod 16; prev SHALL update to the sampled count on every en=1.
REQ-019 prev=15 and count=0 SHALL increment wrap_cnt, modulo 2^WRAP_W.
REQ-020 A count mismatch SHALL set err, increment err_cnt (saturating at 255) and move the FSM to ERROR.
REQ-021 In ERROR, clr_err=1 with no new mismatch SHALL clear err (and num_err) and return to TRACK.
REQ-022 clr_err and a mismatch in the same cycle: the mismatch SHALL win; err stays 1 and err_cnt increments.
REQ-023 clr_err in IDLE or TRACK SHALL have no effect other than clearing any flags already set.
REQ-024 The FSM SHALL remain in ERROR, continuing to count further mismatches, until it is cleared.
REQ-025 count equal to prev (stall) SHALL be a mismatch.

Reset
REQ-026 reset=0 at a rising edge SHALL force IDLE, locked=0, wrap_cnt=0, err=0, err_cnt=0, num_err=0, and clear prev count/num.
REQ-027 Reset asserted mid-operation SHALL take precedence over en and clr_err in that cycle.
REQ-028 The first en=1 sample after reset release SHALL only be captured, never flagged as an error.

Configuration
REQ-029 Macro NUM_CHECK_EN defined: num and num_err ports SHALL exist.
- In TRACK/ERROR, num SHALL be compared exactly to prev_num+STEP whenever a sample is not a restart.
- A num mismatch SHALL set num_err and increment err_cnt once, even when it coincides with a count mismatch.
- A count mismatch still moves the FSM to ERROR.
REQ-030 With NUM_CHECK_EN, count=0 and num=0.0 with prev≠15 SHALL be treated as an upstream restart:
- no error is raised and wrap_cnt does not increment;
- prev_num is set to 0.0;
- the FSM stays in its current state.
REQ-031 Macro NUM_CHECK_EN undefined: num and num_err ports SHALL be absent, checking SHALL be count-only, and count=0 after prev≠15 SHALL be a mismatch.

Verification
REQ-032 Reset, then en=1 for 40 samples from the upstream counter starting at 0/0.0 -> wrap_cnt=2, err=0, err_cnt=0, locked=1.
REQ-033 Sequence 3,4,6,7 -> err=1 one cycle after the 6 is sampled; err_cnt=1; the 7 is accepted with no further error.
REQ-034 In ERROR, apply clr_err=1 together with a mismatching sample -> err stays 1, err_cnt increments to 2; next clr_err alone -> err=0 and FSM in TRACK.
REQ-035 With NUM_CHECK_EN: sample (5,2.5) then (6,3.5) -> num_err=1, err=0, err_cnt=1; then sample (0,0.0) -> restart, no new error, wrap_cnt unchanged.
REQ-036 Drive 300 mismatches -> err_cnt saturates at 255; then reset=0 for one edge -> all outputs 0, locked=0.
REQ-037 en=0 for 10 cycles with count changing arbitrarily -> no output changes; resume en=1 with prev+1 -> no error.
